// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//
// Hazard detection and stall sequencer beside the ID stage of a five-stage
// pipeline. Drives the PC, IF/ID and ID/EX pipeline-register controls.
//
// Hazards detected (operands arrive pre-decoded):
//   - load-use on the EX load, held for LOAD_USE_CYCLES cycles
//     (one extra when the ID instruction is a branch)
//   - branch in ID depending on an EX ALU result (1 cycle)
//   - branch in ID depending on a MEM load (1 cycle)
// ExtHold freezes everything. A taken branch flushes IF/ID. A saturating
// counter records hazard-stall cycles.
//
// Ports:
//   Clock, Reset                  rising-edge clock, async active-low reset
//   IDRs/IDRt, IDUsesRs/IDUsesRt  ID source registers and read flags
//   BranchFromController          ID instruction is a branch
//   BranchFromBC                  branch comparator says taken
//   EXDest/EXRegWrite/EXMemRead   EX producer
//   MEMDest/MEMMemRead            MEM producer
//   ExtHold                       external freeze
//   ClearCount                    synchronous clear of StallCycles
//   PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Branch, Stalled
//   StallCycles                   saturating stall-cycle count
//   dbg_state, dbg_remain         FSM state (0=RUN, 1=STALL) and down-counter
//
// Handshake note: there is no valid/ready handshake here. Every control
// output is a same-cycle combinational function of the inputs and the
// registered state.
module hazard_stall_controller #(
    parameter int REG_W           = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [REG_W-1:0] IDRs,
    input  logic [REG_W-1:0] IDRt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic             BranchFromController,
    input  logic             BranchFromBC,
    input  logic [REG_W-1:0] EXDest,
    input  logic             EXRegWrite,
    input  logic             EXMemRead,
    input  logic [REG_W-1:0] MEMDest,
    input  logic             MEMMemRead,
    input  logic             ExtHold,
    input  logic             ClearCount,
    output logic             PCWriteEnable,
    output logic             IFIDWriteEnable,
    output logic             IDEXFlush,
    output logic             IFIDFlush,
    output logic             Branch,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCycles,
    output logic             dbg_state,
    output logic [3:0]       dbg_remain
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    localparam logic [4:0] LU_LEN = 5'(LOAD_USE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       remain_q, remain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_match, mem_match;
    logic lu, be, bm;
    logic [4:0] n_len;
    logic stall;
    logic taken;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign ex_match  = (EXDest != '0) &&
                       ((IDUsesRs && EXDest == IDRs) || (IDUsesRt && EXDest == IDRt));
    assign mem_match = (MEMDest != '0) &&
                       ((IDUsesRs && MEMDest == IDRs) || (IDUsesRt && MEMDest == IDRt));

    assign lu = EXMemRead && ex_match;
    // A load in EX is covered by the load-use path, so BE excludes it.
    assign be = BranchFromController && EXRegWrite && !EXMemRead && ex_match;
    assign bm = BranchFromController && MEMMemRead && mem_match;

    assign taken = BranchFromController & BranchFromBC;

    always_comb begin
        n_len = 5'd0;
        if (lu) begin
            n_len = LU_LEN + {4'd0, BranchFromController};
        end else if (be || bm) begin
            n_len = 5'd1;
        end
    end

    // Next-state and stall decision. ExtHold freezes state and remain.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        stall    = 1'b0;
        if (!ExtHold) begin
            case (state_q)
                ST_STALL: begin
                    // Hazard inputs are ignored while the sequence runs.
                    stall    = 1'b1;
                    remain_d = remain_q - 4'd1;
                    if (remain_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (n_len != 5'd0) begin
                        stall = 1'b1;
                        if (n_len > 5'd1) begin
                            remain_d = 4'(n_len - 5'd1);
                            state_d  = ST_STALL;
                        end
                    end
                end
            endcase
        end
    end

    // Output decode: reset forcing, then hold, then stall, then normal.
    always_comb begin
        PCWriteEnable   = 1'b1;
        IFIDWriteEnable = 1'b1;
        IDEXFlush       = 1'b0;
        IFIDFlush       = taken;
        Branch          = taken;
        Stalled         = 1'b0;
        if (!Reset) begin
            PCWriteEnable   = 1'b0;
            IFIDWriteEnable = 1'b0;
            IDEXFlush       = 1'b1;
            IFIDFlush       = 1'b0;
            Branch          = 1'b0;
        end else if (ExtHold) begin
            PCWriteEnable   = 1'b0;
            IFIDWriteEnable = 1'b0;
            IFIDFlush       = 1'b0;
            Branch          = 1'b0;
        end else if (stall) begin
            PCWriteEnable   = 1'b0;
            IFIDWriteEnable = 1'b0;
            IDEXFlush       = 1'b1;
            IFIDFlush       = 1'b0;
            Branch          = 1'b0;
            Stalled         = 1'b1;
        end
    end

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ClearCount) begin
            stall_cnt_d = '0;
        end else if (Stalled && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RUN;
            remain_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign dbg_state   = state_q;
    assign dbg_remain  = remain_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  // Output vector order: {PCWriteEnable, IFIDWriteEnable, IDEXFlush,
  //                       IFIDFlush, Branch, Stalled}
  localparam logic [5:0] O_RST  = 6'b001000;
  localparam logic [5:0] O_RUN  = 6'b110000;
  localparam logic [5:0] O_BR   = 6'b110110;
  localparam logic [5:0] O_STL  = 6'b001001;
  localparam logic [5:0] O_HOLD = 6'b000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic id_uses_rs, id_uses_rt, br_ctl, br_bc;
  logic ex_reg_write, ex_mem_read, mem_mem_read, ext_hold, clear_count;

  // Three instances with different parameters share the stimulus;
  // sel picks which one is compared in the current phase.
  logic [5:0]  ctl_1, ctl_2, ctl_3;
  logic [15:0] cnt_1, cnt_3;
  logic [3:0]  cnt_2;
  logic        st_1, st_2, st_3;
  logic [3:0]  rm_1, rm_2, rm_3;
  int          sel;
  logic [21:0] obs;

  hazard_stall_controller #(.REG_W(5), .LOAD_USE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .Clock(clk), .Reset(rst_n), .IDRs(id_rs), .IDRt(id_rt),
    .IDUsesRs(id_uses_rs), .IDUsesRt(id_uses_rt),
    .BranchFromController(br_ctl), .BranchFromBC(br_bc),
    .EXDest(ex_dest), .EXRegWrite(ex_reg_write), .EXMemRead(ex_mem_read),
    .MEMDest(mem_dest), .MEMMemRead(mem_mem_read),
    .ExtHold(ext_hold), .ClearCount(clear_count),
    .PCWriteEnable(ctl_1[5]), .IFIDWriteEnable(ctl_1[4]), .IDEXFlush(ctl_1[3]),
    .IFIDFlush(ctl_1[2]), .Branch(ctl_1[1]), .Stalled(ctl_1[0]),
    .StallCycles(cnt_1), .dbg_state(st_1), .dbg_remain(rm_1)
  );

  hazard_stall_controller #(.REG_W(5), .LOAD_USE_CYCLES(2), .CNT_W(4)) u_dut2 (
    .Clock(clk), .Reset(rst_n), .IDRs(id_rs), .IDRt(id_rt),
    .IDUsesRs(id_uses_rs), .IDUsesRt(id_uses_rt),
    .BranchFromController(br_ctl), .BranchFromBC(br_bc),
    .EXDest(ex_dest), .EXRegWrite(ex_reg_write), .EXMemRead(ex_mem_read),
    .MEMDest(mem_dest), .MEMMemRead(mem_mem_read),
    .ExtHold(ext_hold), .ClearCount(clear_count),
    .PCWriteEnable(ctl_2[5]), .IFIDWriteEnable(ctl_2[4]), .IDEXFlush(ctl_2[3]),
    .IFIDFlush(ctl_2[2]), .Branch(ctl_2[1]), .Stalled(ctl_2[0]),
    .StallCycles(cnt_2), .dbg_state(st_2), .dbg_remain(rm_2)
  );

  hazard_stall_controller #(.REG_W(5), .LOAD_USE_CYCLES(3), .CNT_W(16)) u_dut3 (
    .Clock(clk), .Reset(rst_n), .IDRs(id_rs), .IDRt(id_rt),
    .IDUsesRs(id_uses_rs), .IDUsesRt(id_uses_rt),
    .BranchFromController(br_ctl), .BranchFromBC(br_bc),
    .EXDest(ex_dest), .EXRegWrite(ex_reg_write), .EXMemRead(ex_mem_read),
    .MEMDest(mem_dest), .MEMMemRead(mem_mem_read),
    .ExtHold(ext_hold), .ClearCount(clear_count),
    .PCWriteEnable(ctl_3[5]), .IFIDWriteEnable(ctl_3[4]), .IDEXFlush(ctl_3[3]),
    .IFIDFlush(ctl_3[2]), .Branch(ctl_3[1]), .Stalled(ctl_3[0]),
    .StallCycles(cnt_3), .dbg_state(st_3), .dbg_remain(rm_3)
  );

  always_comb begin
    case (sel)
      1:       obs = {ctl_1, cnt_1};
      2:       obs = {ctl_2, 12'd0, cnt_2};
      default: obs = {ctl_3, cnt_3};
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  string       tag_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic push_exp(input logic [5:0] ctl, input int cnt, input string tag);
    exp_q.push_back({ctl, 16'(cnt)});
    tag_q.push_back(tag);
  endtask

  task automatic compare_head();
    logic [21:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total_cnt++;
    assert (obs === e) pass_cnt++;
    else begin
      $error("FAIL %s: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
             t, obs[21:16], obs[15:0], e[21:16], e[15:0]);
    end
  endtask

  // Expected value goes in when stimulus is driven; the DUT output is
  // sampled mid-cycle on the falling edge.
  task automatic step(input logic [5:0] ctl, input int cnt, input string tag);
    push_exp(ctl, cnt, tag);
    @(negedge clk);
    compare_head();
  endtask

  // Same, but sampled immediately (asynchronous reset response).
  task automatic step_now(input logic [5:0] ctl, input int cnt, input string tag);
    push_exp(ctl, cnt, tag);
    #1;
    compare_head();
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    br_ctl = 1'b0; br_bc = 1'b0;
    ex_dest = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_dest = 5'd0; mem_mem_read = 1'b0;
    ext_hold = 1'b0; clear_count = 1'b0;
  endtask

  task automatic drive_lu(input logic [4:0] rs, input logic with_branch);
    id_rs = rs; id_uses_rs = 1'b1;
    ex_dest = rs; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    br_ctl = with_branch; br_bc = with_branch;
  endtask

  task automatic do_reset(input int dut, input string tag);
    tick();
    sel = dut;
    rst_n = 1'b0;
    drive_idle();
    step(O_RST, 0, tag);
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] r;
    sel = 1;
    drive_idle();
    #12;

    // Phase A: LOAD_USE_CYCLES=1
    do_reset(1, "reset_a");
    step(O_RUN, 0, "a_idle");
    tick(); drive_lu(5'd8, 1'b0);
    step(O_STL, 0, "a_lu_stall");
    tick(); drive_idle();
    step(O_RUN, 1, "a_after_lu");
    tick(); drive_lu(5'd0, 1'b0);
    step(O_RUN, 1, "a_dest_zero");
    tick(); drive_lu(5'd8, 1'b0); id_uses_rs = 1'b0;
    step(O_RUN, 1, "a_rs_unused");
    tick(); drive_idle();
    r = 5'($urandom_range(1, 31));
    id_rt = r; id_uses_rt = 1'b1; ex_dest = r; ex_mem_read = 1'b1;
    step(O_STL, 1, "a_lu_rt_rand");
    tick(); drive_idle();
    step(O_RUN, 2, "a_after_rt");

    // Phase B: LOAD_USE_CYCLES=3, then branch dependencies
    do_reset(3, "reset_b");
    drive_lu(5'd8, 1'b0);
    step(O_STL, 0, "b_lu_c1");
    tick(); drive_idle();
    step(O_STL, 1, "b_lu_c2");
    tick();
    step(O_STL, 2, "b_lu_c3");
    tick();
    step(O_RUN, 3, "b_lu_done");
    tick(); br_ctl = 1'b1; br_bc = 1'b1; id_rt = 5'd5; id_uses_rt = 1'b1;
    ex_dest = 5'd5; ex_reg_write = 1'b1;
    step(O_STL, 3, "b_be_stall");
    tick(); ex_dest = 5'd0; ex_reg_write = 1'b0;
    step(O_BR, 4, "b_be_taken");
    tick(); ex_reg_write = 1'b1;
    step(O_BR, 4, "b_be_dest0");
    tick(); ex_reg_write = 1'b0; mem_dest = 5'd5; mem_mem_read = 1'b1;
    step(O_STL, 4, "b_bm_stall");
    tick(); mem_mem_read = 1'b0; mem_dest = 5'd0; br_bc = 1'b0;
    step(O_RUN, 5, "b_not_taken");

    // Phase C: LOAD_USE_CYCLES=2 with branch and a 2-cycle ExtHold
    do_reset(2, "reset_c");
    drive_lu(5'd9, 1'b1);
    step(O_STL, 0, "c_stall1");
    tick(); ex_mem_read = 1'b0; ex_dest = 5'd0; ext_hold = 1'b1;
    step(O_HOLD, 1, "c_hold1");
    tick();
    step(O_HOLD, 1, "c_hold2");
    tick(); ext_hold = 1'b0;
    step(O_STL, 1, "c_stall2");
    tick();
    step(O_STL, 2, "c_stall3");
    tick();
    step(O_BR, 3, "c_resume_branch");

    // Phase D: reset during a stall sequence
    do_reset(2, "reset_d");
    drive_lu(5'd9, 1'b1);
    step(O_STL, 0, "d_stall1");
    tick();
    rst_n = 1'b0;
    drive_idle();
    step_now(O_RST, 0, "d_async_reset");
    tick(); rst_n = 1'b1;
    step(O_RUN, 0, "d_release_run");
    tick();
    step(O_RUN, 0, "d_no_residual");

    // Phase E: saturation with CNT_W=4, then clear during a stall
    do_reset(2, "reset_e");
    drive_lu(5'd12, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(O_STL, (i > 15) ? 15 : i, "e_sat");
      tick();
    end
    clear_count = 1'b1;
    step(O_STL, 15, "e_clear_with_stall");
    tick(); clear_count = 1'b0; drive_idle();
    step(O_STL, 0, "e_cleared");
    tick();
    step(O_RUN, 1, "e_count_after_clear");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
